// File: rtl/cnn_pkg.sv
// Shared constants, derived sizes and the scheduler state type for the conv layer datapath.
package cnn_pkg;

  localparam int DEF_INPUT_SIZE  = 34;
  localparam int DEF_FILTER_SIZE = 7;
  localparam int DEF_NUM_FILTERS = 16;
  localparam int DEF_STRIDE      = 2;

  function automatic int f_out_size(input int in_size, input int k, input int stride);
    return (in_size - k) / stride + 1;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int f_cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_OUT_SIZE = f_out_size(DEF_INPUT_SIZE, DEF_FILTER_SIZE, DEF_STRIDE);
  localparam int DEF_IN_AW    = f_cw(DEF_INPUT_SIZE * DEF_INPUT_SIZE);
  localparam int DEF_W_AW     = f_cw(DEF_NUM_FILTERS * DEF_FILTER_SIZE * DEF_FILTER_SIZE);
  localparam int DEF_OUT_AW   = f_cw(DEF_NUM_FILTERS * DEF_OUT_SIZE * DEF_OUT_SIZE);

  typedef enum logic [2:0] {IDLE, RUN, WAIT, WRITE, DONE} sched_state_t;

endpackage

// File: rtl/conv_loop_counter.sv
// Cascaded wrap counter over kernel column, kernel row, output column, output row and filter.
module conv_loop_counter import cnn_pkg::*; #(
  parameter int K           = DEF_FILTER_SIZE,
  parameter int OUT_SIZE    = DEF_OUT_SIZE,
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int KW          = f_cw(K),
  parameter int OW          = f_cw(OUT_SIZE),
  parameter int FW          = f_cw(NUM_FILTERS)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [KW-1:0] o_kx,
  output logic [KW-1:0] o_ky,
  output logic [OW-1:0] o_c,
  output logic [OW-1:0] o_r,
  output logic [FW-1:0] o_f,
  output logic          o_kx_last,
  output logic          o_ky_last,
  output logic          o_c_last,
  output logic          o_r_last,
  output logic          o_f_last
);

  logic [KW-1:0] r_kx, r_ky;
  logic [OW-1:0] r_c, r_r;
  logic [FW-1:0] r_f;
  logic          w_inc_ky, w_inc_c, w_inc_r, w_inc_f;

  assign o_kx_last = (r_kx == KW'(K - 1));
  assign o_ky_last = (r_ky == KW'(K - 1));
  assign o_c_last  = (r_c == OW'(OUT_SIZE - 1));
  assign o_r_last  = (r_r == OW'(OUT_SIZE - 1));
  assign o_f_last  = (r_f == FW'(NUM_FILTERS - 1));

  assign w_inc_ky = i_inc & o_kx_last;
  assign w_inc_c  = w_inc_ky & o_ky_last;
  assign w_inc_r  = w_inc_c & o_c_last;
  assign w_inc_f  = w_inc_r & o_r_last;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_kx <= '0;
      r_ky <= '0;
      r_c  <= '0;
      r_r  <= '0;
      r_f  <= '0;
    end else if (i_clr) begin
      r_kx <= '0;
      r_ky <= '0;
      r_c  <= '0;
      r_r  <= '0;
      r_f  <= '0;
    end else begin
      if (i_inc)    r_kx <= o_kx_last ? '0 : r_kx + 1'b1;
      if (w_inc_ky) r_ky <= o_ky_last ? '0 : r_ky + 1'b1;
      if (w_inc_c)  r_c  <= o_c_last  ? '0 : r_c + 1'b1;
      if (w_inc_r)  r_r  <= o_r_last  ? '0 : r_r + 1'b1;
      if (w_inc_f)  r_f  <= o_f_last  ? '0 : r_f + 1'b1;
    end
  end

  assign o_kx = r_kx;
  assign o_ky = r_ky;
  assign o_c  = r_c;
  assign o_r  = r_r;
  assign o_f  = r_f;

endmodule

// File: rtl/conv_layer_scheduler.sv
// Tap/pixel sequencer for one strided conv layer: buffer read addresses, MAC control, output writes.
//   state | meaning
//   IDLE  | waiting for start, counters at zero
//   RUN   | one input/weight read per cycle for the current pixel
//   WAIT  | read pipeline drains, last tap accumulates
//   WRITE | out_valid held until out_ready
//   DONE  | one-cycle done pulse
module conv_layer_scheduler import cnn_pkg::*; #(
  parameter int INPUT_SIZE  = DEF_INPUT_SIZE,
  parameter int FILTER_SIZE = DEF_FILTER_SIZE,
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int STRIDE      = DEF_STRIDE,
  parameter int OUT_SIZE    = f_out_size(INPUT_SIZE, FILTER_SIZE, STRIDE),
  parameter int IN_AW       = f_cw(INPUT_SIZE * INPUT_SIZE),
  parameter int W_AW        = f_cw(NUM_FILTERS * FILTER_SIZE * FILTER_SIZE),
  parameter int OUT_AW      = f_cw(NUM_FILTERS * OUT_SIZE * OUT_SIZE)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              in_rd_en,
  output logic [IN_AW-1:0]  in_addr,
  output logic              w_rd_en,
  output logic [W_AW-1:0]   w_addr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_AW-1:0] out_addr
);

  localparam int KW = f_cw(FILTER_SIZE);
  localparam int OW = f_cw(OUT_SIZE);
  localparam int FW = f_cw(NUM_FILTERS);

  sched_state_t      r_state;
  logic              r_busy, r_done, r_in_rd_en, r_mac_en, r_mac_clr, r_out_valid;
  logic              r_first_tap, r_last_tap, r_pix_last;
  logic [IN_AW-1:0]  r_in_addr;
  logic [W_AW-1:0]   r_w_addr;
  logic [OUT_AW-1:0] r_out_addr;

  logic [KW-1:0]     w_kx, w_ky;
  logic [OW-1:0]     w_c, w_r;
  logic [FW-1:0]     w_f;
  logic              w_kx_last, w_ky_last, w_c_last, w_r_last, w_f_last;
  logic              w_issue, w_tap_first, w_tap_last, w_pix_last;
  logic [IN_AW-1:0]  w_in_addr;
  logic [W_AW-1:0]   w_w_addr;
  logic [OUT_AW-1:0] w_out_addr;

  // The counter advances on every issued tap, so after a pixel's last tap it already
  // points at the next pixel; out_addr and the last-pixel flag are captured at that edge.
  conv_loop_counter #(
    .K          (FILTER_SIZE),
    .OUT_SIZE   (OUT_SIZE),
    .NUM_FILTERS(NUM_FILTERS)
  ) u_cnt (
    .clk      (clk),
    .rstb     (rstb),
    .i_clr    (abort),
    .i_inc    (w_issue),
    .o_kx     (w_kx),
    .o_ky     (w_ky),
    .o_c      (w_c),
    .o_r      (w_r),
    .o_f      (w_f),
    .o_kx_last(w_kx_last),
    .o_ky_last(w_ky_last),
    .o_c_last (w_c_last),
    .o_r_last (w_r_last),
    .o_f_last (w_f_last)
  );

  assign w_tap_first = (w_kx == '0) && (w_ky == '0);
  assign w_tap_last  = w_kx_last & w_ky_last;
  assign w_pix_last  = w_c_last & w_r_last & w_f_last;

  assign w_in_addr  = IN_AW'((32'(w_r) * 32'(STRIDE) + 32'(w_ky)) * 32'(INPUT_SIZE)
                             + 32'(w_c) * 32'(STRIDE) + 32'(w_kx));
  assign w_w_addr   = W_AW'(32'(w_f) * 32'(FILTER_SIZE * FILTER_SIZE)
                            + 32'(w_ky) * 32'(FILTER_SIZE) + 32'(w_kx));
  assign w_out_addr = OUT_AW'(32'(w_f) * 32'(OUT_SIZE * OUT_SIZE)
                              + 32'(w_r) * 32'(OUT_SIZE) + 32'(w_c));

  always_comb begin
    w_issue = 1'b0;
    if (!abort) begin
      case (r_state)
        IDLE:    w_issue = start;
        RUN:     w_issue = !r_last_tap;
        WRITE:   w_issue = r_out_valid & out_ready & !r_pix_last;
        default: w_issue = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_rd_en  <= 1'b0;
      r_mac_en    <= 1'b0;
      r_mac_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_first_tap <= 1'b0;
      r_last_tap  <= 1'b0;
      r_pix_last  <= 1'b0;
      r_in_addr   <= '0;
      r_w_addr    <= '0;
      r_out_addr  <= '0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_rd_en  <= 1'b0;
      r_mac_en    <= 1'b0;
      r_mac_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_first_tap <= 1'b0;
      r_last_tap  <= 1'b0;
      r_pix_last  <= 1'b0;
      r_in_addr   <= '0;
      r_w_addr    <= '0;
      r_out_addr  <= '0;
    end else begin
      r_done     <= 1'b0;
      r_in_rd_en <= w_issue;
      r_mac_en   <= r_in_rd_en;
      r_mac_clr  <= r_in_rd_en & r_first_tap;
      if (w_issue) begin
        r_in_addr   <= w_in_addr;
        r_w_addr    <= w_w_addr;
        r_first_tap <= w_tap_first;
        r_last_tap  <= w_tap_last;
        if (w_tap_last) begin
          r_out_addr <= w_out_addr;
          r_pix_last <= w_pix_last;
        end
      end
      case (r_state)
        IDLE: if (start) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end
        RUN: if (r_last_tap) r_state <= WAIT;
        WAIT: begin
          r_state     <= WRITE;
          r_out_valid <= 1'b1;
        end
        WRITE: if (r_out_valid && out_ready) begin
          r_out_valid <= 1'b0;
          if (r_pix_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= RUN;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign in_rd_en  = r_in_rd_en;
  assign w_rd_en   = r_in_rd_en;
  assign in_addr   = r_in_addr;
  assign w_addr    = r_w_addr;
  assign mac_en    = r_mac_en;
  assign mac_clr   = r_mac_clr;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench: default-size scheduler for sequencing/backpressure/abort/reset, small instance for a full layer.
module tb_conv_layer_scheduler;

  logic clk = 1'b0;
  logic rstb, start, abort, out_ready;
  logic busy, done, in_rd_en, w_rd_en, mac_en, mac_clr, out_valid;
  logic [10:0] in_addr;
  logic [9:0]  w_addr;
  logic [11:0] out_addr;

  logic start_s;
  logic busy_s, done_s, in_rd_en_s, w_rd_en_s, mac_en_s, mac_clr_s, out_valid_s;
  logic [6:0] in_addr_s;
  logic [4:0] w_addr_s;
  logic [4:0] out_addr_s;

  int checks = 0;
  int errors = 0;
  int m_done_cnt = 0;
  int s_done_cnt = 0;
  int s_hs = 0;
  int s_first = -1;
  int s_last_in = -1;
  int s_last_out = -1;
  logic s_prev_rd = 1'b0;

  always #5 clk = ~clk;

  conv_layer_scheduler dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort), .busy(busy), .done(done),
    .in_rd_en(in_rd_en), .in_addr(in_addr), .w_rd_en(w_rd_en), .w_addr(w_addr),
    .mac_en(mac_en), .mac_clr(mac_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr)
  );

  // 9x9 input, 3x3 kernel, stride 2, 2 filters: 4x4 outputs, 32 pixels of 11 cycles.
  conv_layer_scheduler #(
    .INPUT_SIZE(9), .FILTER_SIZE(3), .NUM_FILTERS(2), .STRIDE(2)
  ) dut_s (
    .clk(clk), .rstb(rstb), .start(start_s), .abort(1'b0), .busy(busy_s), .done(done_s),
    .in_rd_en(in_rd_en_s), .in_addr(in_addr_s), .w_rd_en(w_rd_en_s), .w_addr(w_addr_s),
    .mac_en(mac_en_s), .mac_clr(mac_clr_s), .out_valid(out_valid_s), .out_ready(1'b1),
    .out_addr(out_addr_s)
  );

  always @(negedge clk) begin
    if (done) m_done_cnt++;
    if (done_s) s_done_cnt++;
    if (in_rd_en_s && !s_prev_rd) s_first = int'(in_addr_s);
    if (in_rd_en_s) s_last_in = int'(in_addr_s);
    if (out_valid_s) begin
      s_hs++;
      s_last_out = int'(out_addr_s);
    end
    s_prev_rd = in_rd_en_s;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk(tag, 64'({busy, done, in_rd_en, w_rd_en, mac_en, mac_clr, out_valid,
                  in_addr, w_addr, out_addr}), 64'd0);
  endtask

  initial begin
    int n, t, q, f, r, c;
    rstb = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; start_s = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset_outputs");
    chk("reset_small_busy", 64'(busy_s), 64'd0);
    rstb = 1'b1;
    @(negedge clk);

    // Full layer on the small instance: done at cycle 32*11+1.
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    n = 1;
    while (!done_s && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("s_done_cycle", 64'(n), 64'd353);
    chk("s_busy_at_done", 64'(busy_s), 64'd0);
    @(negedge clk);
    chk("s_done_width", 64'(done_s), 64'd0);
    repeat (3) @(negedge clk);
    chk("s_done_count", 64'(s_done_cnt), 64'd1);
    chk("s_handshakes", 64'(s_hs), 64'd32);
    chk("s_last_pix_first_in", 64'(s_first), 64'd60);
    chk("s_last_in", 64'(s_last_in), 64'd80);
    chk("s_last_out_addr", 64'(s_last_out), 64'd31);

    // First pixel with a second start mid-walk that must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 49; k++) begin
      t = k - 1;
      chk("p0_in_addr", 64'(in_addr), 64'((t / 7) * 34 + t % 7));
      chk("p0_w_addr", 64'(w_addr), 64'(t));
      chk("p0_rd_en", 64'({in_rd_en, w_rd_en}), 64'd3);
      chk("p0_mac_clr", 64'(mac_clr), 64'(k == 2));
      chk("p0_mac_en", 64'(mac_en), 64'(k >= 2));
      chk("p0_busy", 64'(busy), 64'd1);
      start = (k == 10);
      @(negedge clk);
    end
    start = 1'b0;
    chk("wait_rd_en", 64'(in_rd_en), 64'd0);
    chk("wait_mac_en", 64'(mac_en), 64'd1);
    chk("wait_mac_clr", 64'(mac_clr), 64'd0);
    chk("wait_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    // Backpressure: out_ready low through cycles 51..55.
    for (int k = 51; k <= 55; k++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_addr", 64'(out_addr), 64'd0);
      chk("bp_rd_en", 64'(in_rd_en), 64'd0);
      if (k < 55) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("p1_rd_en", 64'(in_rd_en), 64'd1);
    chk("p1_in_addr", 64'(in_addr), 64'd2);
    chk("p1_w_addr", 64'(w_addr), 64'd0);
    chk("p1_out_valid", 64'(out_valid), 64'd0);

    // Pixels 1..196: 50 cycles from first tap to out_valid, then next pixel's first tap.
    for (int p = 1; p <= 196; p++) begin
      n = 0;
      while (!out_valid && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("pix_latency", 64'(n), 64'd50);
      chk("pix_out_addr", 64'(out_addr), 64'(p));
      @(negedge clk);
      q = p + 1;
      f = q / 196;
      r = (q % 196) / 14;
      c = q % 14;
      chk("pix_rd_en", 64'(in_rd_en), 64'd1);
      chk("pix_first_in", 64'(in_addr), 64'((2 * r) * 34 + 2 * c));
      chk("pix_first_w", 64'(w_addr), 64'(f * 49));
    end

    // Abort mid-run.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_strobes", 64'({in_rd_en, w_rd_en, mac_en, mac_clr, out_valid, done}), 64'd0);
    // start and abort together: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("sa_busy_next", 64'(busy), 64'd0);
    chk("sa_rd_en", 64'(in_rd_en), 64'd0);

    // Fresh start, abort at cycle 20, then replay.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      t = k - 1;
      chk("ab_in_addr", 64'(in_addr), 64'((t / 7) * 34 + t % 7));
      if (k < 20) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab20_busy", 64'(busy), 64'd0);
    chk("ab20_strobes", 64'({in_rd_en, w_rd_en, mac_en, mac_clr, out_valid}), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      t = k - 1;
      chk("replay_in_addr", 64'(in_addr), 64'((t / 7) * 34 + t % 7));
      chk("replay_w_addr", 64'(w_addr), 64'(t));
      @(negedge clk);
    end

    // Reach WRITE, then reset asynchronously between clock edges.
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_write", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("rst_valid_held", 64'(out_valid), 64'd1);
    #2;
    rstb = 1'b0;
    #1;
    chk_idle_zero("async_reset_outputs");
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk_idle_zero("post_reset_idle");
    chk("main_done_count", 64'(m_done_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_layer_scheduler.md
Name: conv_layer_scheduler

Overview:
- Sequences one strided 2-D convolution layer of the CNN: walks filter, output row, output column and kernel tap.
- Per tap, issues read addresses to the input-feature buffer and the weight buffer, and drives the MAC accumulator's enable/clear.
- Per output pixel, presents one write request with a valid/ready handshake to the output feature buffer.
- Sits between the top-level layer controller (start/done) and the conv datapath memories and MAC.

Parameters:
- INPUT_SIZE, 34, input feature map width = height.
- FILTER_SIZE, 7, kernel width = height (K).
- NUM_FILTERS, 16, output channels.
- STRIDE, 2, convolution stride.
- Derived localparams:
  - OUT_SIZE = (INPUT_SIZE-FILTER_SIZE)/STRIDE+1 = 14 (floor division).
  - IN_AW = clog2(INPUT_SIZE^2) = 11.
  - W_AW = clog2(NUM_FILTERS*K^2) = 10.
  - OUT_AW = clog2(NUM_FILTERS*OUT_SIZE^2) = 12.

Ports:
- clk  in  1  clock.
- rstb  in  1  reset, asynchronous, active-low.
- start  in  1  launch layer; sampled only in IDLE.
- abort  in  1  synchronous cancel; forces IDLE next cycle, no done pulse.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last output handshake.
- in_rd_en  out  1  input buffer read strobe.
- in_addr  out  IN_AW  (r*STRIDE+ky)*INPUT_SIZE + (c*STRIDE+kx).
- w_rd_en  out  1  weight buffer read strobe; always equals in_rd_en.
- w_addr  out  W_AW  f*K*K + ky*K + kx.
- mac_en  out  1  accumulate this cycle's product; in_rd_en delayed 1 cycle (read latency fixed at 1).
- mac_clr  out  1  with mac_en: load product instead of add; first-tap flag delayed 1 cycle.
- out_valid  out  1  output pixel ready to write; accumulator result is valid.
- out_ready  in  1  output buffer accepts.
- out_addr  out  OUT_AW  f*OUT_SIZE^2 + r*OUT_SIZE + c.

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE.
- States and transitions:
  - IDLE: start=1 -> RUN. Counters f=r=c=ky=kx=0.
  - RUN: in_rd_en=w_rd_en=1 every cycle. kx increments; wraps to 0 and increments ky. Tap (K-1,K-1) issued -> WAIT. Exactly K*K taps per pixel.
  - WAIT: 1 cycle. mac_en for the last tap occurs here. -> WRITE.
  - WRITE: out_valid=1 with out_addr stable; no reads. Advances only on out_valid&out_ready:
    - c increments; wraps to 0 and increments r; r wraps to 0 and increments f.
    - If the pixel was (NUM_FILTERS-1, OUT_SIZE-1, OUT_SIZE-1) -> DONE; else -> RUN with ky=kx=0.
  - DONE: done=1 for 1 cycle, busy drops in the same cycle -> IDLE.
- Timing:
  - start at edge E0: first tap visible cycles 1..49, WAIT cycle 50, out_valid from cycle 51.
  - Minimum 51 cycles per pixel.
  - Layer total 3136 pixels x 51 = 159936 cycles with out_ready tied high.
- Boundary conditions:
  - start while busy: ignored.
  - start and abort in the same IDLE cycle: abort wins, stay IDLE.
  - abort in any state: next cycle IDLE; all strobes, out_valid and busy deassert; no done.
  - out_valid, once asserted, is never dropped without a handshake, except on abort or reset.
  - Async reset mid-operation: immediate return to reset values.
  - Address arithmetic: unsigned, computed at full width, then truncated to the port width. For the defaults no overflow is possible; max in_addr is 1120.
  - Columns beyond the last full stride window (input column 33) are never addressed.

Decomposition:
- Shared package cnn_pkg:
  - Default layer constants INPUT_SIZE, FILTER_SIZE, NUM_FILTERS, STRIDE.
  - Derived OUT_SIZE and address widths.
  - State enum sched_state_t {IDLE, RUN, WAIT, WRITE, DONE}.
- One sub-module: conv_loop_counter, the cascaded 5-level wrap counter (kx, ky, c, r, f) with per-level increment enable and last-flags. The scheduler FSM and address arithmetic stay in conv_layer_scheduler.

Test Plan:
- Start pulse, out_ready=1:
  - in_addr cycles 1..49 = 0..6, 34..40, ..., 204..210.
  - w_addr = 0..48.
  - mac_clr only at cycle 2.
  - out_valid at cycle 51 with out_addr=0.
- Continue:
  - Pixel 2 first in_addr=2, out_addr=1.
  - Pixel 15 (r=1,c=0) first in_addr=68, out_addr=14.
  - Filter 1 first w_addr=49, out_addr=196.
- Full run, out_ready=1:
  - Last pixel first in_addr=910, last in_addr=1120, out_addr=3135.
  - done pulses exactly once at cycle 159937.
  - 3136 handshakes total.
- Backpressure: out_ready low 5 cycles during the first WRITE.
  - out_valid held, out_addr=0 stable, no rd_en.
  - Pixel 2 reads start the cycle after the handshake.
- Abort at cycle 20 of the first pixel:
  - Next cycle busy=0, strobes 0, no done.
  - A new start replays from in_addr=0.
- Reset mid-operation:
  - rstb low during WRITE: all outputs 0 asynchronously.
  - A second start while busy is ignored: the address sequence is unchanged.
